// File: rtl/key_cmd_ctrl_if.sv
// Key/command bundle for key_cmd_ctrl.
// Carries the three raw active-low push-buttons towards the controller and the
// command outputs, mode and busy flag back out towards the random-number core.
//   master : the controller side (samples keys, drives commands)
//   slave  : the board/core side (drives keys, observes commands)
interface key_cmd_ctrl_if;
  logic       i_key_start;  // raw start button, active-low, asynchronous
  logic       i_key_stop;   // raw stop button, active-low, asynchronous
  logic       i_key_show;   // raw show button, active-low, asynchronous
  logic       o_start;      // start command pulse
  logic       o_stop;       // stop command pulse
  logic       o_show;       // show command window
  logic [1:0] o_state;      // mode: 0 idle, 1 run, 2 halt, 3 show
  logic       o_busy;       // any command output high

  modport master (
    input  i_key_start,
    input  i_key_stop,
    input  i_key_show,
    output o_start,
    output o_stop,
    output o_show,
    output o_state,
    output o_busy
  );

  modport slave (
    output i_key_start,
    output i_key_stop,
    output i_key_show,
    input  o_start,
    input  o_stop,
    input  o_show,
    input  o_state,
    input  o_busy
  );
endinterface

// File: rtl/key_cmd_ctrl.sv
// Front-end command initiator for the Lab1 random-number core.
// Each raw button is synchronised (2 flops) and debounced; a debounced press
// becomes a one-cycle event. Events are arbitrated (stop > start > show),
// dropped while a command is in flight, and filtered by a mode machine that
// mirrors the core, so only legal commands reach it.
// Ports:
//   i_clk   : system clock
//   i_rst   : synchronous reset, active-high
//   bus_io  : key_cmd_ctrl_if.master
//             in  i_key_start/i_key_stop/i_key_show (raw, active-low)
//             out o_start/o_stop (PULSE_CYC wide), o_show (SHOW_CYC wide),
//                 o_state (mode), o_busy
module key_cmd_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned PULSE_CYC    = 2,
  parameter int unsigned SHOW_CYC     = 50
) (
  input  logic           i_clk,
  input  logic           i_rst,
  key_cmd_ctrl_if.master bus_io
);

  // Debounce counter only needs to hold DEBOUNCE_CYC-1: the toggle happens on
  // the edge that would take it to DEBOUNCE_CYC.
  localparam int unsigned DebW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned PulseW = $clog2(PULSE_CYC + 1);
  localparam int unsigned ShowW  = $clog2(SHOW_CYC + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2,
    StShow = 2'd3
  } state_e;

  // Key index: 0 start, 1 stop, 2 show. Levels stay raw-polarity (1 = released).
  logic [2:0] key_raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] deb_q, deb_d;
  logic [2:0] evt_q, evt_d;
  logic [DebW-1:0] cnt_q [3];
  logic [DebW-1:0] cnt_d [3];

  assign key_raw = {bus_io.i_key_show, bus_io.i_key_stop, bus_io.i_key_start};

  // ---------------------------------------------------------------------------
  // Synchroniser + debouncer
  // ---------------------------------------------------------------------------
  always_comb begin
    deb_d = deb_q;
    evt_d = '0;
    for (int k = 0; k < 3; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (cnt_q[k] == DebW'(DEBOUNCE_CYC - 1)) begin
          deb_d[k] = sync2_q[k];
          // Only released->pressed (1->0) produces an event.
          evt_d[k] = ~sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + DebW'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      deb_q   <= 3'b111;
      evt_q   <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      evt_q   <= evt_d;
      for (int k = 0; k < 3; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration: stop > start > show; losers in the same cycle are dropped.
  // ---------------------------------------------------------------------------
  logic ev_start, ev_stop, ev_show;

  assign ev_stop  = evt_q[1];
  assign ev_start = evt_q[0] & ~evt_q[1];
  assign ev_show  = evt_q[2] & ~evt_q[1] & ~evt_q[0];

  // ---------------------------------------------------------------------------
  // Mode machine and command generators
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic               start_q, start_d;
  logic               stop_q, stop_d;
  logic               show_q, show_d;
  logic [PulseW-1:0]  pcnt_q, pcnt_d;
  logic [ShowW-1:0]   scnt_q, scnt_d;
  logic               busy;

  assign busy = start_q | stop_q | show_q;

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    stop_d  = stop_q;
    show_d  = show_q;
    pcnt_d  = pcnt_q;
    scnt_d  = scnt_q;

    // Counters are loaded with 1 on the launching edge, so reaching the
    // terminal count means the output has been high for that many edges.
    if (start_q || stop_q) begin
      if (pcnt_q == PulseW'(PULSE_CYC)) begin
        start_d = 1'b0;
        stop_d  = 1'b0;
      end else begin
        pcnt_d = pcnt_q + PulseW'(1);
      end
    end

    if (show_q) begin
      if (scnt_q == ShowW'(SHOW_CYC)) begin
        show_d  = 1'b0;
        state_d = StHalt;
      end else begin
        scnt_d = scnt_q + ShowW'(1);
      end
    end

    // Events seen while busy are simply lost; nothing is queued.
    if (!busy) begin
      unique case (state_q)
        StIdle: begin
          if (ev_start) begin
            state_d = StRun;
            start_d = 1'b1;
            pcnt_d  = PulseW'(1);
          end
        end
        StRun: begin
          if (ev_stop) begin
            state_d = StHalt;
            stop_d  = 1'b1;
            pcnt_d  = PulseW'(1);
          end else if (ev_start) begin
            start_d = 1'b1;
            pcnt_d  = PulseW'(1);
          end
        end
        StHalt: begin
          if (ev_start) begin
            state_d = StRun;
            start_d = 1'b1;
            pcnt_d  = PulseW'(1);
          end else if (ev_show) begin
            state_d = StShow;
            show_d  = 1'b1;
            scnt_d  = ShowW'(1);
          end
        end
        StShow: begin
          // Not reachable without an open show window; recover to HALT.
          state_d = StHalt;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      show_q  <= 1'b0;
      pcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      show_q  <= show_d;
      pcnt_q  <= pcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign bus_io.o_start = start_q;
  assign bus_io.o_stop  = stop_q;
  assign bus_io.o_show  = show_q;
  assign bus_io.o_state = state_q;
  assign bus_io.o_busy  = busy;

endmodule

// File: tb/tb_key_cmd_ctrl.sv
// Self-checking bench for key_cmd_ctrl: directed scenarios followed by random
// key activity, every cycle compared against a behavioural model.
module tb_key_cmd_ctrl;
  localparam int unsigned Deb = 4;
  localparam int unsigned Pul = 2;
  localparam int unsigned Shw = 50;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  key_cmd_ctrl_if bus ();

  key_cmd_ctrl #(
    .DEBOUNCE_CYC (Deb),
    .PULSE_CYC    (Pul),
    .SHOW_CYC     (Shw)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  // Keys as {show, stop, start}, raw polarity (0 = pressed).
  logic [2:0] pipe[$];   // raw samples still in flight through the synchroniser
  logic [2:0] acc;       // accepted (debounced) level
  int         run[3];    // edges the seen level has disagreed with acc
  logic [2:0] evt_m;     // press events available to the command layer
  int         mode;      // 0 idle, 1 run, 2 halt, 3 show
  int         kind;      // command in flight: 0 none, 1 start, 2 stop, 3 show
  int         left;      // edges the in-flight command stays high

  task automatic model_reset();
    pipe = {3'b111, 3'b111};
    acc  = 3'b111;
    for (int k = 0; k < 3; k++) run[k] = 0;
    evt_m = 3'b000;
    mode = 0;
    kind = 0;
    left = 0;
  endtask

  task automatic model_edge(input logic r, input logic [2:0] raw);
    int ev;
    logic [2:0] seen;
    if (r) begin
      model_reset();
      return;
    end
    if (left > 0) begin
      left--;
      if (left == 0) begin
        if (kind == 3) mode = 2;
        kind = 0;
      end
    end else begin
      ev = evt_m[1] ? 2 : evt_m[0] ? 1 : evt_m[2] ? 3 : 0;
      case (mode)
        0: if (ev == 1) begin mode = 1; kind = 1; left = Pul; end
        1: if (ev == 2) begin mode = 2; kind = 2; left = Pul; end
           else if (ev == 1) begin kind = 1; left = Pul; end
        2: if (ev == 1) begin mode = 1; kind = 1; left = Pul; end
           else if (ev == 3) begin mode = 3; kind = 3; left = Shw; end
        default: ;
      endcase
    end
    seen = pipe.pop_front();
    pipe.push_back(raw);
    evt_m = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (seen[k] != acc[k]) begin
        run[k]++;
        if (run[k] == int'(Deb)) begin
          acc[k]   = seen[k];
          run[k]   = 0;
          evt_m[k] = ~seen[k];
        end
      end else begin
        run[k] = 0;
      end
    end
  endtask

  function automatic logic [5:0] model_outs();
    logic [1:0] m;
    m = mode[1:0];
    return {(kind == 1 && left > 0), (kind == 2 && left > 0), (kind == 3 && left > 0),
            m, (left > 0)};
  endfunction

  function automatic logic [5:0] dut_outs();
    return {bus.o_start, bus.o_stop, bus.o_show, bus.o_state, bus.o_busy};
  endfunction

  function automatic logic sel_out(input int sel);
    case (sel)
      0:       return bus.o_start;
      1:       return bus.o_stop;
      default: return bus.o_show;
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [2:0] raw;
    logic r;
    raw = {bus.i_key_show, bus.i_key_stop, bus.i_key_start};
    r   = rst;
    @(posedge clk);
    model_edge(r, raw);
    #1;
    check("cycle_outputs", 32'(dut_outs()), 32'(model_outs()));
  endtask

  task automatic set_keys(input logic [2:0] kv);
    bus.i_key_start = kv[0];
    bus.i_key_stop  = kv[1];
    bus.i_key_show  = kv[2];
  endtask

  task automatic hold_keys(input logic [2:0] kv, input int n);
    set_keys(kv);
    repeat (n) tick();
  endtask

  // Edges from the first edge that samples the current inputs until sel is high.
  task automatic wait_high(input int sel, output int n);
    n = 0;
    forever begin
      tick();
      if (sel_out(sel)) break;
      n++;
      if (n >= 40) break;
    end
  endtask

  // Edges for which sel remains high, starting from a cycle where it is high.
  task automatic width_of(input int sel, output int w);
    w = 0;
    while (sel_out(sel) && w < 200) begin
      tick();
      w++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int w;
    int hold[3];
    logic [2:0] kv;

    model_reset();
    rst = 1'b1;
    set_keys(3'b111);
    repeat (2) tick();
    rst = 1'b0;
    check("reset_outputs", 32'(dut_outs()), 32'h0);

    // Basic start then stop.
    set_keys(3'b110);
    wait_high(0, lat);
    check("start_latency", lat, 6);
    width_of(0, w);
    check("start_width", w, Pul);
    check("state_run", 32'(bus.o_state), 1);
    hold_keys(3'b111, 12);

    set_keys(3'b101);
    wait_high(1, lat);
    check("stop_latency", lat, 6);
    width_of(1, w);
    check("stop_width", w, Pul);
    check("state_halt", 32'(bus.o_state), 2);
    hold_keys(3'b111, 12);

    // Show window, with start/stop pressed inside it.
    set_keys(3'b011);
    wait_high(2, lat);
    check("show_latency", lat, 6);
    check("state_show", 32'(bus.o_state), 3);
    hold_keys(3'b100, 10);
    set_keys(3'b111);
    width_of(2, w);
    check("show_width", w + 10, Shw);
    check("show_exit_halt", 32'(bus.o_state), 2);
    hold_keys(3'b111, 10);

    // Reset at show cycle 10 while start is held.
    set_keys(3'b011);
    wait_high(2, lat);
    check("show2_latency", lat, 6);
    hold_keys(3'b010, 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("reset_mid_show", 32'(dut_outs()), 32'h0);
    wait_high(0, lat);
    check("start_after_reset", lat, 6);
    check("state_after_reset", 32'(bus.o_state), 1);
    hold_keys(3'b111, 12);

    // Bounce from idle.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) hold_keys((i % 2 == 0) ? 3'b110 : 3'b111, 2);
    hold_keys(3'b111, 12);
    check("bounce_idle", 32'(bus.o_state), 0);

    // Illegal commands.
    hold_keys(3'b101, 10);
    hold_keys(3'b111, 10);
    hold_keys(3'b011, 10);
    hold_keys(3'b111, 10);
    check("illegal_idle", 32'(bus.o_state), 0);
    hold_keys(3'b110, 10);
    hold_keys(3'b111, 10);
    hold_keys(3'b011, 10);
    hold_keys(3'b111, 10);
    check("show_in_run", 32'(bus.o_state), 1);
    set_keys(3'b110);
    wait_high(0, lat);
    check("restart_latency", lat, 6);
    width_of(0, w);
    check("restart_width", w, Pul);
    check("restart_state", 32'(bus.o_state), 1);
    hold_keys(3'b111, 12);

    // Simultaneous start+stop in run: stop wins.
    hold_keys(3'b100, 15);
    hold_keys(3'b111, 10);
    check("simul_stop_wins", 32'(bus.o_state), 2);

    // Stop event landing during the start pulse is discarded.
    hold_keys(3'b110, 1);
    hold_keys(3'b100, 20);
    hold_keys(3'b111, 12);
    check("busy_drop", 32'(bus.o_state), 1);

    // Random key activity with occasional reset.
    for (int k = 0; k < 3; k++) hold[k] = 0;
    kv = 3'b111;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (hold[k] == 0) begin
          kv[k]   = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
          hold[k] = $urandom_range(1, 14);
        end else begin
          hold[k]--;
        end
      end
      set_keys(kv);
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
